fir_tap_loader: RTL and testbench
=================================

Name: fir_tap_loader

Overview:
- Initiator for the FIR filter's coefficient-write port (tap_wr_en / tap_wr_addr / tap_wr_data).
- Accepts a coefficient stream over a valid/ready handshake and writes taps 0..NUM_TAPS-1 in order.
- Also provides a one-shot "clear all taps" sequence.
- Holds the filter enable low while any tap sequence is in progress, so the filter never runs on a half-updated coefficient set.

Parameters:
- NUM_TAPS, 51, number of filter taps (50th order).
- TAP_W, 16, coefficient width in bits.
- ADDR_W, 6, tap address width; must satisfy 2**ADDR_W >= NUM_TAPS.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous reset, active-high.
- i_load_start  in  1  single-cycle request to start a coefficient load.
- i_clear_start  in  1  single-cycle request to zero all taps.
- i_coef_valid  in  1  upstream coefficient valid.
- i_coef_data  in  TAP_W  upstream coefficient, two's complement.
- o_coef_ready  out  1  loader accepts a coefficient this cycle.
- i_fir_en_req  in  1  user filter-enable request.
- o_fir_en  out  1  gated enable to the filter.
- o_tap_wr_en  out  1  tap write strobe.
- o_tap_wr_addr  out  ADDR_W  tap write address.
- o_tap_wr_data  out  TAP_W  tap write data.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse when a sequence completes.
- o_err  out  1  one-cycle pulse when a start request is rejected.
- o_checksum  out  TAP_W  coefficient checksum (see Optional Feature).

Behaviour:
- Clock and reset: one clock, i_clk; reset i_rst is synchronous, active-high.
- Reset values: state=IDLE, tap counter=0, all registered outputs 0 (o_tap_wr_en, o_tap_wr_addr, o_tap_wr_data, o_done, o_err, o_checksum).
- Reset mid-sequence: aborts immediately to IDLE. Taps already written are not restored. No o_done is issued.
- States: IDLE, LOAD, CLEAR, DONE.
- IDLE:
  - i_clear_start -> CLEAR.
  - else i_load_start -> LOAD.
  - Both asserted in the same cycle: clear wins; the load is dropped silently.
- LOAD:
  - o_coef_ready = 1 (combinational from state).
  - Each cycle with i_coef_valid & o_coef_ready: the next cycle presents o_tap_wr_en=1, o_tap_wr_addr=count, o_tap_wr_data=i_coef_data; count increments.
  - Gaps in valid produce gaps in writes; no timeout.
  - Handshake at count=NUM_TAPS-1 -> DONE.
- CLEAR: no handshake. One write per cycle with data 0, addresses 0..NUM_TAPS-1 (51 consecutive cycles), then DONE.
- DONE: lasts 1 cycle, o_busy=1, then IDLE.
  - o_done pulses in the same cycle as the final tap write (addr NUM_TAPS-1).
- Counter: resets to 0 on entry to LOAD/CLEAR; it never wraps past NUM_TAPS-1.
- o_fir_en = i_fir_en_req & (state==IDLE), combinational.
  - The filter is disabled from the first cycle of LOAD/CLEAR through DONE.
  - It is re-enabled the cycle after DONE.
- Start while busy: any i_load_start or i_clear_start outside IDLE is ignored and pulses o_err the next cycle. The ongoing sequence continues unaffected.
- Latency: load start sampled at cycle 0; ready from cycle 1. With continuous valid, writes occur on cycles 2..52 and o_done on cycle 52. Clear: writes on cycles 2..52, done on cycle 52.
- i_coef_data outside LOAD is ignored; o_coef_ready is 0 in IDLE, CLEAR and DONE.

Optional Feature:
- Macro: FIR_TAP_CHECKSUM_EN.
- Defined:
  - o_checksum is a TAP_W-bit modular (wrap-around) sum of every o_tap_wr_data written in the current sequence.
  - Zeroed on entry to LOAD/CLEAR; final value valid from the o_done cycle until the next start.
  - A clear sequence yields 0.
- Not defined: o_checksum is tied to 0 and no accumulator is synthesised.

Decomposition:
- Package fir_tap_pkg holds:
  - NUM_TAPS, TAP_W, ADDR_W defaults.
  - State enumeration (IDLE, LOAD, CLEAR, DONE).
  - Type aliases tap_t (signed TAP_W) and tap_addr_t (ADDR_W).
- The FIR filter imports the same constants.
- No sub-module: the counter and FSM are small enough to stay in one module.

Test Plan:
- Reset then load 51 coefficients 1..51 with continuous valid -> writes addr 0..50 with data 1..50,51 on cycles 2..52; o_done at cycle 52; o_fir_en=0 cycles 1..52.
- Load with i_coef_valid toggling every other cycle -> 51 writes spread over about 102 cycles, addresses strictly sequential, no duplicated or skipped address.
- Clear start -> 51 consecutive writes of 0 to addr 0..50; o_coef_ready stays 0; o_done on the last write.
- i_load_start and i_clear_start in the same IDLE cycle -> CLEAR sequence only; o_err=0. A second i_load_start during CLEAR -> o_err pulse; clear completes normally.
- Assert i_rst after 20 handshakes -> next cycle IDLE, o_tap_wr_en=0, o_busy=0, no o_done. A new load then starts at addr 0.
- With FIR_TAP_CHECKSUM_EN, load coefficients all 16'h1000 -> o_checksum = 51*0x1000 mod 2^16 = 16'h3000 at o_done. Without the macro, o_checksum = 0 throughout.

Source files
------------

// File: rtl/fir_tap_pkg.sv
// Shared constants and types for the FIR filter and its coefficient loader.
package fir_tap_pkg;

    localparam int NUM_TAPS = 51;
    localparam int TAP_W    = 16;
    localparam int ADDR_W   = 6;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CLEAR,
        DONE
    } state_t;

    typedef logic signed [TAP_W-1:0] tap_t;
    typedef logic [ADDR_W-1:0]       tap_addr_t;

endpackage

// File: rtl/fir_tap_loader.sv
// Writes FIR taps from a valid/ready coefficient stream, or zeroes them all.
// Optional FIR_TAP_CHECKSUM_EN adds a modular sum of the written coefficients.
module fir_tap_loader #(
    parameter int NUM_TAPS = fir_tap_pkg::NUM_TAPS,
    parameter int TAP_W    = fir_tap_pkg::TAP_W,
    parameter int ADDR_W   = fir_tap_pkg::ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load_start,
    input  logic              i_clear_start,
    input  logic              i_coef_valid,
    input  logic [TAP_W-1:0]  i_coef_data,
    output logic              o_coef_ready,
    input  logic              i_fir_en_req,
    output logic              o_fir_en,
    output logic              o_tap_wr_en,
    output logic [ADDR_W-1:0] o_tap_wr_addr,
    output logic [TAP_W-1:0]  o_tap_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [TAP_W-1:0]  o_checksum
);
    import fir_tap_pkg::*;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_TAPS - 1);

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] count;
    logic              wr;
    logic              last;
    logic              start;
    logic [TAP_W-1:0]  wr_data;

    assign last    = (count == LAST);
    assign start   = i_load_start | i_clear_start;
    assign wr      = ((state == LOAD) && i_coef_valid) || (state == CLEAR);
    assign wr_data = (state == LOAD) ? i_coef_data : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (i_clear_start) state_n = CLEAR;
                     else if (i_load_start) state_n = LOAD;
            LOAD:    if (i_coef_valid && last) state_n = DONE;
            CLEAR:   if (last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        o_coef_ready = (state == LOAD);
        o_busy       = (state != IDLE);
        o_fir_en     = i_fir_en_req && (state == IDLE);
    end

    // Counter sits at 0 while idle, so every sequence starts from tap 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count         <= '0;
            o_tap_wr_en   <= 1'b0;
            o_tap_wr_addr <= '0;
            o_tap_wr_data <= '0;
            o_done        <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            o_tap_wr_en <= wr;
            o_done      <= wr && last;
            o_err       <= (state != IDLE) && start;
            if (wr) begin
                o_tap_wr_addr <= count;
                o_tap_wr_data <= wr_data;
            end
            if (state == IDLE) begin
                count <= '0;
            end else if (wr && !last) begin
                count <= count + 1'b1;
            end
        end
    end

`ifdef FIR_TAP_CHECKSUM_EN
    logic [TAP_W-1:0] sum_q;

    // Accumulates alongside the write register so the final sum lines up with o_done.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sum_q <= '0;
        end else if ((state == IDLE) && start) begin
            sum_q <= '0;
        end else if (wr) begin
            sum_q <= sum_q + wr_data;
        end
    end

    assign o_checksum = sum_q;
`else
    assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_fir_tap_loader.sv
// Scoreboard bench for fir_tap_loader: expected tap writes are queued by stimulus
// and checked by an independent monitor.
module tb_fir_tap_loader;
    import fir_tap_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_start;
    logic              clear_start;
    logic              coef_valid;
    logic [TAP_W-1:0]  coef_data;
    logic              coef_ready;
    logic              fir_en_req;
    logic              fir_en;
    logic              tap_wr_en;
    logic [ADDR_W-1:0] tap_wr_addr;
    logic [TAP_W-1:0]  tap_wr_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [TAP_W-1:0]  checksum;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [TAP_W-1:0]  data;
        logic              last;
    } wr_exp_t;

    wr_exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_tap_loader #(
        .NUM_TAPS(NUM_TAPS),
        .TAP_W   (TAP_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_load_start (load_start),
        .i_clear_start(clear_start),
        .i_coef_valid (coef_valid),
        .i_coef_data  (coef_data),
        .o_coef_ready (coef_ready),
        .i_fir_en_req (fir_en_req),
        .o_fir_en     (fir_en),
        .o_tap_wr_en  (tap_wr_en),
        .o_tap_wr_addr(tap_wr_addr),
        .o_tap_wr_data(tap_wr_data),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_checksum   (checksum)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented write must match the head of the expected queue.
    always @(negedge clk) begin
        wr_exp_t e;
        if (tap_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(tap_wr_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(tap_wr_addr), 32'(e.addr));
                chk("wr_data", 32'(tap_wr_data), 32'(e.data));
                chk("wr_done", 32'(done), 32'(e.last));
            end
        end else if (done !== 1'b0) begin
            chk("stray_done", 32'(done), 32'd0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Runs a full load; gap inserts one idle-valid cycle before each coefficient.
    task automatic do_load(input int mode, input bit gap, input logic [TAP_W-1:0] exp_cs);
        logic [TAP_W-1:0] d;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            d = (mode == 0) ? TAP_W'(i + 1) : 16'h1000;
            if (gap) begin
                coef_valid = 1'b0;
                coef_data  = 16'hDEAD;
                #1;
                chk("gap_ready", 32'(coef_ready), 32'd1);
                tick();
            end
            coef_valid = 1'b1;
            coef_data  = d;
            exp_q.push_back('{addr: ADDR_W'(i), data: d, last: (i == NUM_TAPS - 1)});
            #1;
            if (i == 0 || i == NUM_TAPS - 1) begin
                chk("load_ready", 32'(coef_ready), 32'd1);
                chk("load_fir_en", 32'(fir_en), 32'd0);
            end
            tick();
        end
        coef_valid = 1'b0;
        #1;
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_fir_en", 32'(fir_en), 32'd0);
        chk("done_ready", 32'(coef_ready), 32'd0);
        chk("load_checksum", 32'(checksum), 32'(exp_cs));
        tick();
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_fir_en", 32'(fir_en), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    task automatic do_clear(input bit with_load, input int busy_load_at);
        clear_start = 1'b1;
        load_start  = with_load;
        tick();
        clear_start = 1'b0;
        load_start  = 1'b0;
        #1;
        chk("clear_no_err", 32'(err), 32'd0);
        for (int i = 0; i < NUM_TAPS; i++)
            exp_q.push_back('{addr: ADDR_W'(i), data: '0, last: (i == NUM_TAPS - 1)});
        for (int i = 0; i < NUM_TAPS; i++) begin
            coef_valid = 1'b1;
            coef_data  = 16'h7777;
            load_start = (i == busy_load_at);
            #1;
            chk("clear_ready", 32'(coef_ready), 32'd0);
            if (i == 0 || i == NUM_TAPS - 1) begin
                chk("clear_busy", 32'(busy), 32'd1);
                chk("clear_fir_en", 32'(fir_en), 32'd0);
            end
            if (busy_load_at >= 0 && i == busy_load_at + 1)
                chk("busy_start_err", 32'(err), 32'd1);
            tick();
        end
        load_start = 1'b0;
        coef_valid = 1'b0;
        #1;
        chk("clear_done_busy", 32'(busy), 32'd1);
        chk("clear_checksum", 32'(checksum), 32'd0);
        tick();
        #1;
        chk("clear_idle_busy", 32'(busy), 32'd0);
        chk("clear_queue_drained", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    initial begin
        logic [TAP_W-1:0] cs_seq;
        logic [TAP_W-1:0] cs_const;
`ifdef FIR_TAP_CHECKSUM_EN
        cs_seq   = 16'h052E;
        cs_const = 16'h3000;
`else
        cs_seq   = 16'h0000;
        cs_const = 16'h0000;
`endif
        rst = 1'b1;
        load_start = 1'b0;
        clear_start = 1'b0;
        coef_valid = 1'b0;
        coef_data = '0;
        fir_en_req = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_wr_en", 32'(tap_wr_en), 32'd0);
        chk("rst_wr_addr", 32'(tap_wr_addr), 32'd0);
        chk("rst_wr_data", 32'(tap_wr_data), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(coef_ready), 32'd0);
        rst = 1'b0;
        tick();
        #1;
        chk("idle_fir_en_on", 32'(fir_en), 32'd1);

        do_load(0, 1'b0, cs_seq);
        do_load(0, 1'b1, cs_seq);
        do_clear(1'b0, -1);
        do_clear(1'b1, 10);

        // Abort a load with reset after 20 handshakes.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            coef_valid = 1'b1;
            coef_data  = TAP_W'(16'h0100 + i);
            exp_q.push_back('{addr: ADDR_W'(i), data: TAP_W'(16'h0100 + i), last: 1'b0});
            tick();
        end
        coef_valid = 1'b0;
        rst = 1'b1;
        tick();
        #1;
        chk("abort_wr_en", 32'(tap_wr_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_queue", 32'(exp_q.size()), 32'd0);
        rst = 1'b0;
        tick();

        do_load(1, 1'b0, cs_const);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
